// File: rtl/mem_edit_pkg.sv
// Shared types for the memory-stage edit responder: FSM states, request packet layout
// and the packet unpacker.
package mem_edit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } memState_t;

  // Packet layout for the default 32/32 build: {we, addr, wdata}, wdata in the low bits.
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_DATA_W   = 32;
  localparam int PKT_DATA_LSB = 0;
  localparam int PKT_ADDR_LSB = PKT_DATA_LSB + DEF_DATA_W;
  localparam int PKT_WE_BIT   = PKT_ADDR_LSB + DEF_ADDR_W;

  // The unpacker works on a widest-case container so it serves any width pair up to 64/64.
  localparam int FIELD_MAX_W = 64;
  localparam int PKT_MAX_W   = 1 + 2 * FIELD_MAX_W;

  typedef struct packed {
    logic                   we;
    logic [FIELD_MAX_W-1:0] addr;
    logic [FIELD_MAX_W-1:0] wdata;
  } memReq_t;

  function automatic logic [FIELD_MAX_W-1:0] fieldMask(input int w);
    logic [FIELD_MAX_W-1:0] m;
    if (w >= FIELD_MAX_W) begin
      m = {FIELD_MAX_W{1'b1}};
    end else begin
      m = ~({FIELD_MAX_W{1'b1}} << w);
    end
    return m;
  endfunction

  function automatic memReq_t unpackPacket(input logic [PKT_MAX_W-1:0] pkt,
                                           input int addrW,
                                           input int dataW);
    memReq_t                r;
    logic [PKT_MAX_W-1:0]   sh;
    sh      = pkt >> PKT_DATA_LSB;
    r.wdata = sh[FIELD_MAX_W-1:0] & fieldMask(dataW);
    sh      = pkt >> (PKT_DATA_LSB + dataW);
    r.addr  = sh[FIELD_MAX_W-1:0] & fieldMask(addrW);
    sh      = pkt >> (PKT_DATA_LSB + dataW + addrW);
    r.we    = sh[0];
    return r;
  endfunction

endpackage

// File: rtl/mem_edit_responder_if.sv
// Request/response bus between the pipeline MEM stage (master) and the edit responder (slave).
interface mem_edit_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic [ADDR_W+DATA_W:0]   req_packet;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [DATA_W-1:0]        resp_rdata;
  logic                     resp_err;
  logic                     busy;

  modport master (
    output req_valid, req_packet, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_packet, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/mem_word_array.sv
// Single-port synchronous word RAM; a read or write happens only on an enabled edge and the
// read register holds its value otherwise.
module mem_word_array #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] index,
  input  logic [DATA_W-1:0]              wdata,
  output logic [DATA_W-1:0]              rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_r;

  // Array storage and registered read port.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_r[index] <= wdata;
      end else begin
        rdata_r <= mem_r[index];
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mem_edit_responder.sv
// Fixed-latency responder executing {we, addr, wdata} packets against a word array.
// Optional build macro MEM_ALIGN_CHECK_EN adds misalignment / out-of-range fault reporting.
module mem_edit_responder
  import mem_edit_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                clk,
  input  logic                rst,
  mem_edit_responder_if.slave bus
);

  localparam int               IDX_W       = $clog2(DEPTH_WORDS);
  localparam int               PKT_W       = 1 + ADDR_W + DATA_W;
  localparam int               CNT_W       = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam bit               DIRECT_RESP = (LATENCY == 1);

  memState_t         state_r;
  logic [CNT_W-1:0]  counter_r;
  logic              reqWe_r;
  logic [ADDR_W-1:0] reqAddr_r;
  logic [DATA_W-1:0] reqWdata_r;
  logic              respValid_r;
  logic              respErr_r;
  logic              respShowData_r;
  logic              busy_r;
  logic              reqReady_r;

  logic [PKT_MAX_W-1:0] pktExt_s;
  memReq_t              pktFields_s;
  logic                 inWe_s;
  logic [ADDR_W-1:0]    inAddr_s;
  logic [DATA_W-1:0]    inWdata_s;
  logic                 curWe_s;
  logic [ADDR_W-1:0]    curAddr_s;
  logic [DATA_W-1:0]    curWdata_s;
  logic                 enterResp_s;
  logic                 fault_s;
  logic                 ramEn_s;
  logic                 ramWe_s;
  logic [DATA_W-1:0]    ramRdata_s;

  // Split the incoming packet into its fields.
  always_comb begin
    pktExt_s              = {PKT_MAX_W{1'b0}};
    pktExt_s[PKT_W-1:0]   = bus.req_packet;
    pktFields_s           = unpackPacket(pktExt_s, ADDR_W, DATA_W);
    inWe_s                = pktFields_s.we;
    inAddr_s              = ADDR_W'(pktFields_s.addr);
    inWdata_s             = DATA_W'(pktFields_s.wdata);
  end

  // The array is accessed on the edge that enters RESP; with LATENCY==1 that is the
  // acceptance edge itself, so the live packet is used instead of the latch.
  always_comb begin
    enterResp_s = 1'b0;
    case (state_r)
      IDLE:    enterResp_s = bus.req_valid && DIRECT_RESP;
      WAIT:    enterResp_s = (counter_r == CNT_ONE);
      RESP:    enterResp_s = 1'b0;
      default: enterResp_s = 1'b0;
    endcase
    if (state_r == IDLE) begin
      curWe_s    = inWe_s;
      curAddr_s  = inAddr_s;
      curWdata_s = inWdata_s;
    end else begin
      curWe_s    = reqWe_r;
      curAddr_s  = reqAddr_r;
      curWdata_s = reqWdata_r;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  // Fault on a non-word-aligned address or a word index beyond the array.
  always_comb begin
    fault_s = (curAddr_s[1:0] != 2'b00) ||
              (curAddr_s[ADDR_W-1:IDX_W+2] != {(ADDR_W-IDX_W-2){1'b0}});
  end
`else
  logic unusedAddr_s;
  assign fault_s      = 1'b0;
  assign unusedAddr_s = ^{curAddr_s[1:0], curAddr_s[ADDR_W-1:IDX_W+2]};
`endif

  // A reset edge must not commit a pending write.
  assign ramEn_s = enterResp_s && rst;
  assign ramWe_s = curWe_s && !fault_s;

  mem_word_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .en    (ramEn_s),
    .we    (ramWe_s),
    .index (curAddr_s[IDX_W+1:2]),
    .wdata (curWdata_s),
    .rdata (ramRdata_s)
  );

  // Control FSM with latency counter, packet latch and response flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r        <= IDLE;
      counter_r      <= {CNT_W{1'b0}};
      reqWe_r        <= 1'b0;
      reqAddr_r      <= {ADDR_W{1'b0}};
      reqWdata_r     <= {DATA_W{1'b0}};
      respValid_r    <= 1'b0;
      respErr_r      <= 1'b0;
      respShowData_r <= 1'b0;
      busy_r         <= 1'b0;
      reqReady_r     <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            reqWe_r    <= inWe_s;
            reqAddr_r  <= inAddr_s;
            reqWdata_r <= inWdata_s;
            counter_r  <= CNT_LOAD;
            busy_r     <= 1'b1;
            reqReady_r <= 1'b0;
            if (DIRECT_RESP) begin
              state_r        <= RESP;
              respValid_r    <= 1'b1;
              respErr_r      <= fault_s;
              respShowData_r <= !curWe_s && !fault_s;
            end else begin
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          counter_r <= counter_r - CNT_ONE;
          if (counter_r == CNT_ONE) begin
            state_r        <= RESP;
            respValid_r    <= 1'b1;
            respErr_r      <= fault_s;
            respShowData_r <= !curWe_s && !fault_s;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state_r     <= IDLE;
            respValid_r <= 1'b0;
            busy_r      <= 1'b0;
            reqReady_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          respValid_r <= 1'b0;
          busy_r      <= 1'b0;
          reqReady_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = reqReady_r;
  assign bus.resp_valid = respValid_r;
  assign bus.resp_err   = respErr_r;
  assign bus.busy       = busy_r;
  // Writes and faults report zero; the RAM read register holds stale data in those cases.
  assign bus.resp_rdata = respShowData_r ? ramRdata_s : {DATA_W{1'b0}};

endmodule
